// File: rtl/interconnect_sfft_r4_to_butterfly_if.sv
// ============================================================================
// Module   : interconnect_sfft_r4_to_butterfly_if
// Brief    : Sample-in / 4-lane-beat-out bus between sub-FFT and butterfly.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface interconnect_sfft_r4_to_butterfly_if #(
    parameter int SIZE_BUFFER   = 4,
    parameter int DATA_FFT_SIZE = 16
);
    logic [DATA_FFT_SIZE-1:0]   i_in_data_i;
    logic [DATA_FFT_SIZE-1:0]   i_in_data_q;
    logic                       i_valid;
    logic                       o_wayt_data;
    logic [4*DATA_FFT_SIZE-1:0] o_out_data_i;
    logic [4*DATA_FFT_SIZE-1:0] o_out_data_q;
    logic [SIZE_BUFFER-2:0]     o_out_index;
    logic                       o_outvalid;
    logic                       o_last;
    logic                       i_butterfly_wayt_data;
    logic                       o_frame_done;

    modport master (
        output i_in_data_i, i_in_data_q, i_valid, i_butterfly_wayt_data,
        input  o_wayt_data, o_out_data_i, o_out_data_q, o_out_index,
        input  o_outvalid, o_last, o_frame_done
    );

    modport slave (
        input  i_in_data_i, i_in_data_q, i_valid, i_butterfly_wayt_data,
        output o_wayt_data, o_out_data_i, o_out_data_q, o_out_index,
        output o_outvalid, o_last, o_frame_done
    );
endinterface

`default_nettype wire

// File: rtl/interconnect_sfft_r4_to_butterfly.sv
// ============================================================================
// Module   : interconnect_sfft_r4_to_butterfly
// Brief    : Regroups four serial sub-FFT blocks into a parallel 4-lane stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module interconnect_sfft_r4_to_butterfly #(
    parameter int SIZE_BUFFER   = 4,
    parameter int DATA_FFT_SIZE = 16
) (
    input  wire logic                            i_clk,
    input  wire logic                            i_reset,
    interconnect_sfft_r4_to_butterfly_if.slave   bus
);
    localparam int c_cw    = SIZE_BUFFER - 1;
    // Address width is kept at least 1 bit so the degenerate single-sample case still indexes cleanly
    localparam int c_aw    = (SIZE_BUFFER > 2) ? SIZE_BUFFER - 2 : 1;
    localparam int c_depth = 1 << c_aw;
    localparam logic [c_cw-1:0] c_cnt_max = c_cw'((1 << (SIZE_BUFFER - 2)) - 1);

    localparam logic [1:0] BLK0  = 2'd0;
    localparam logic [1:0] BLK1  = 2'd1;
    localparam logic [1:0] BLK2  = 2'd2;
    localparam logic [1:0] MERGE = 2'd3;

    logic [1:0]      r_blk, w_blk_next;
    logic [c_cw-1:0] r_cnt, w_cnt_next;
    logic            w_wayt, w_merge, w_xfer, w_cnt_last;
    logic [c_aw-1:0] w_addr;

    logic [DATA_FFT_SIZE-1:0]   w_rd_i [3];
    logic [DATA_FFT_SIZE-1:0]   w_rd_q [3];

    logic [4*DATA_FFT_SIZE-1:0] r_out_i, r_out_q;
    logic [c_cw-1:0]            r_index;
    logic                       r_outvalid, r_last, r_frame_done;

    assign w_cnt_last = (r_cnt == c_cnt_max);
    assign w_addr     = r_cnt[c_aw-1:0];
    assign w_xfer     = bus.i_valid & w_wayt;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_blk <= BLK0;
            r_cnt <= '0;
        end else begin
            r_blk <= w_blk_next;
            r_cnt <= w_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_blk_next = r_blk;
        w_cnt_next = r_cnt;
        if (w_xfer) begin
            if (w_cnt_last) begin
                w_cnt_next = '0;
                w_blk_next = r_blk + 2'd1;
            end else begin
                w_cnt_next = r_cnt + c_cw'(1);
            end
        end
    end

    // Output logic: only the merge block can be throttled by the butterfly
    always_comb begin
        w_merge = 1'b0;
        w_wayt  = 1'b1;
        case (r_blk)
            BLK0, BLK1, BLK2: begin
                w_merge = 1'b0;
                w_wayt  = 1'b1;
            end
            MERGE: begin
                w_merge = 1'b1;
                w_wayt  = !r_outvalid | bus.i_butterfly_wayt_data;
            end
            default: begin
                w_merge = 1'b0;
                w_wayt  = 1'b1;
            end
        endcase
    end

    generate
        for (genvar g = 0; g < 3; g++) begin : g_lane_buf
            logic [DATA_FFT_SIZE-1:0] r_mem_i [c_depth];
            logic [DATA_FFT_SIZE-1:0] r_mem_q [c_depth];

            always_ff @(posedge i_clk) begin
                if (w_xfer && (r_blk == 2'(g))) begin
                    r_mem_i[w_addr] <= bus.i_in_data_i;
                    r_mem_q[w_addr] <= bus.i_in_data_q;
                end
            end

            assign w_rd_i[g] = r_mem_i[w_addr];
            assign w_rd_q[g] = r_mem_q[w_addr];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_i      <= '0;
            r_out_q      <= '0;
            r_index      <= '0;
            r_outvalid   <= 1'b0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_outvalid & bus.i_butterfly_wayt_data & r_last;
            if (w_xfer && w_merge) begin
                r_out_i    <= {bus.i_in_data_i, w_rd_i[2], w_rd_i[1], w_rd_i[0]};
                r_out_q    <= {bus.i_in_data_q, w_rd_q[2], w_rd_q[1], w_rd_q[0]};
                r_index    <= r_cnt;
                r_outvalid <= 1'b1;
                r_last     <= w_cnt_last;
            end else if (r_outvalid && bus.i_butterfly_wayt_data) begin
                r_outvalid <= 1'b0;
                r_last     <= 1'b0;
            end
        end
    end

    assign bus.o_wayt_data  = w_wayt;
    assign bus.o_out_data_i = r_out_i;
    assign bus.o_out_data_q = r_out_q;
    assign bus.o_out_index  = r_index;
    assign bus.o_outvalid   = r_outvalid;
    assign bus.o_last       = r_last;
    assign bus.o_frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_interconnect_sfft_r4_to_butterfly.sv
// ============================================================================
// Module   : tb_interconnect_sfft_r4_to_butterfly
// Brief    : Self-checking bench for the sub-FFT to butterfly regrouping stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_interconnect_sfft_r4_to_butterfly;
    localparam int SB = 4;
    localparam int W  = 16;

    typedef struct {
        int base;
        bit gaps;
        int stall_k;
        int nframes;
        bit rst_mid;
        int exp_beats;
    } vec_t;

    typedef struct {
        logic [2:0]   k;
        logic [63:0]  di;
        logic [63:0]  dq;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    interconnect_sfft_r4_to_butterfly_if #(.SIZE_BUFFER(SB), .DATA_FFT_SIZE(W)) bus ();

    interconnect_sfft_r4_to_butterfly #(.SIZE_BUFFER(SB), .DATA_FFT_SIZE(W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    beat_t sb[$];
    int    beats_seen = 0;
    int    dones_seen = 0;
    int    stall_k = -1;
    int    stall_left = 0;
    int    xfer_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] si(input int base, input int n);
        return 16'(base + n);
    endfunction

    function automatic logic [15:0] sq(input int base, input int n);
        return 16'(-(base + n));
    endfunction

    task automatic check_reset_state();
        check("rst_outvalid", 64'(bus.o_outvalid), 64'd0);
        check("rst_last", 64'(bus.o_last), 64'd0);
        check("rst_done", 64'(bus.o_frame_done), 64'd0);
        check("rst_wayt", 64'(bus.o_wayt_data), 64'd1);
        check("rst_data_i", bus.o_out_data_i, 64'd0);
        check("rst_data_q", bus.o_out_data_q, 64'd0);
        check("rst_index", 64'(bus.o_out_index), 64'd0);
    endtask

    task automatic send(input int base, input int n, input bit gaps);
        bit    acc;
        beat_t b;
        if (gaps && n < 12) begin
            for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
                bus.i_valid = 1'b0;
                bus.i_in_data_i = 16'hdead;
                @(posedge clk); #1;
            end
        end
        bus.i_in_data_i = si(base, n);
        bus.i_in_data_q = sq(base, n);
        bus.i_valid     = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = bus.o_wayt_data;
            @(posedge clk); #1;
            xfer_cycles++;
        end
        if (!acc) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else if (n >= 12) begin
            b.k    = 3'(n - 12);
            b.last = (n == 15);
            b.di   = '0;
            b.dq   = '0;
            for (int l = 0; l < 4; l++) begin
                b.di[l*16 +: 16] = si(base, 4*l + n - 12);
                b.dq[l*16 +: 16] = sq(base, 4*l + n - 12);
            end
            sb.push_back(b);
            check("latency_valid", 64'(bus.o_outvalid), 64'd1);
            check("latency_index", 64'(bus.o_out_index), 64'(n - 12));
        end
    endtask

    // Downstream ready, optionally stalled while a chosen beat is presented
    initial begin
        bus.i_butterfly_wayt_data = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_k >= 0 && stall_left > 0 && bus.o_outvalid &&
                bus.o_out_index == 3'(stall_k)) begin
                bus.i_butterfly_wayt_data = 1'b0;
                stall_left--;
            end else begin
                bus.i_butterfly_wayt_data = 1'b1;
            end
        end
    end

    // Output monitor and scoreboard
    initial begin
        bit    exp_done;
        bit    have_hold;
        beat_t held;
        beat_t e;
        exp_done  = 1'b0;
        have_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_done  = 1'b0;
                have_hold = 1'b0;
            end else begin
                if (bus.o_frame_done || exp_done)
                    check("frame_done", 64'(bus.o_frame_done), 64'(exp_done));
                if (bus.o_frame_done) dones_seen++;
                exp_done = 1'b0;
                if (have_hold) begin
                    check("hold_index", 64'(bus.o_out_index), 64'(held.k));
                    check("hold_i", bus.o_out_data_i, held.di);
                    check("hold_q", bus.o_out_data_q, held.dq);
                    check("hold_valid", 64'(bus.o_outvalid), 64'd1);
                    have_hold = 1'b0;
                end
                if (bus.o_outvalid && bus.i_butterfly_wayt_data) begin
                    beats_seen++;
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 64'(bus.o_out_index), 64'hffff);
                    end else begin
                        e = sb.pop_front();
                        check("beat_index", 64'(bus.o_out_index), 64'(e.k));
                        check("beat_i", bus.o_out_data_i, e.di);
                        check("beat_q", bus.o_out_data_q, e.dq);
                        check("beat_last", 64'(bus.o_last), 64'(e.last));
                    end
                    if (bus.o_last) exp_done = 1'b1;
                end else if (bus.o_outvalid) begin
                    held.k    = bus.o_out_index;
                    held.di   = bus.o_out_data_i;
                    held.dq   = bus.o_out_data_q;
                    held.last = bus.o_last;
                    have_hold = 1'b1;
                    if (bus.o_out_index != 3'd3)
                        check("wayt_while_held", 64'(bus.o_wayt_data), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   b0;
        int   d0;
        vecs[0] = '{base: 0,   gaps: 1'b0, stall_k: -1, nframes: 1, rst_mid: 1'b0, exp_beats: 4};
        vecs[1] = '{base: 0,   gaps: 1'b0, stall_k: 1,  nframes: 1, rst_mid: 1'b0, exp_beats: 4};
        vecs[2] = '{base: 0,   gaps: 1'b0, stall_k: -1, nframes: 2, rst_mid: 1'b0, exp_beats: 8};
        vecs[3] = '{base: 0,   gaps: 1'b1, stall_k: -1, nframes: 1, rst_mid: 1'b0, exp_beats: 4};
        vecs[4] = '{base: 0,   gaps: 1'b0, stall_k: -1, nframes: 1, rst_mid: 1'b1, exp_beats: 4};

        bus.i_valid     = 1'b0;
        bus.i_in_data_i = '0;
        bus.i_in_data_q = '0;

        // Reset asserted between clock edges must act immediately
        #2 rst = 1'b1;
        #1 check_reset_state();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            b0 = beats_seen;
            d0 = dones_seen;
            if (vecs[v].rst_mid) begin
                for (int n = 0; n < 10; n++) send(vecs[v].base + 500, n, 1'b0);
                bus.i_valid = 1'b0;
                @(negedge clk); #1;
                rst = 1'b1;
                #1 check_reset_state();
                @(posedge clk); #1;
                rst = 1'b0;
            end
            xfer_cycles = 0;
            stall_k     = vecs[v].stall_k;
            stall_left  = 3;
            for (int f = 0; f < vecs[v].nframes; f++)
                for (int n = 0; n < 16; n++)
                    send(vecs[v].base + 100*f, n, vecs[v].gaps);
            bus.i_valid = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            stall_k = -1;
            check("vec_beats", 64'(beats_seen - b0), 64'(vecs[v].exp_beats));
            check("vec_frame_done", 64'(dones_seen - d0), 64'(vecs[v].nframes));
            if (!vecs[v].gaps && vecs[v].stall_k < 0)
                check("vec_no_bubble", 64'(xfer_cycles), 64'(16 * vecs[v].nframes));
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
